// File: rtl/field_buffer.sv
// Banked field memory: 1-cycle processor read port, priority write slot shared by processor, bank clear FSM and host port.
// Optional FIELD_BYPASS_EN forwards a same-address processor write onto the next field_out.
module field_buffer #(
  parameter int d_width      = 8,
  parameter int bufp_width   = 3,
  parameter int fieldp_width = 5,
  localparam int AW          = bufp_width + fieldp_width
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AW-1:0]         buf_fieldp,
  output logic [d_width-1:0]    field_out,
  input  logic [AW-1:0]         buf_fieldwp,
  input  logic                  field_write_en,
  input  logic [d_width-1:0]    field_in,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic                  host_write,
  input  logic [AW-1:0]         host_adr,
  input  logic [d_width-1:0]    host_wdata,
  output logic [d_width-1:0]    host_rdata,
  output logic                  host_rvalid,
  input  logic                  clear_req,
  input  logic [bufp_width-1:0] clear_bank,
  output logic                  clear_busy
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [bufp_width-1:0]   bank_q, bank_d;
  logic [fieldp_width-1:0] cnt_q, cnt_d;

  logic [d_width-1:0] mem [DEPTH];

  logic               host_acc;
  logic               mem_we;
  logic [AW-1:0]      mem_wadr;
  logic [d_width-1:0] mem_wdata;
  logic [d_width-1:0] rd_data_p0;

  assign host_ready = !field_write_en && (state_q == IDLE);
  assign host_acc   = host_valid && host_ready;
  assign clear_busy = (state_q == CLEAR);

  // Clear sequencer: one zeroed word per cycle the processor leaves the write slot free
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          bank_d  = clear_bank;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (!field_write_en) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bank_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      cnt_q   <= cnt_d;
    end
  end

  // Single write slot: processor, then clear step, then host
  always_comb begin
    mem_we    = 1'b0;
    mem_wadr  = host_adr;
    mem_wdata = host_wdata;
    if (field_write_en) begin
      mem_we    = 1'b1;
      mem_wadr  = buf_fieldwp;
      mem_wdata = field_in;
    end else if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_wadr  = {bank_q, cnt_q};
      mem_wdata = '0;
    end else if (host_acc && host_write) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wadr] <= mem_wdata;
  end

  // Read stage p0 -> registered field_out
  always_comb begin
    rd_data_p0 = mem[buf_fieldp];
`ifdef FIELD_BYPASS_EN
    if (field_write_en && (buf_fieldwp == buf_fieldp)) rd_data_p0 = field_in;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      field_out <= '0;
    end else begin
      field_out <= rd_data_p0;
    end
  end

  // Host read response stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      host_rvalid <= host_acc && !host_write;
      if (host_acc && !host_write) host_rdata <= mem[host_adr];
    end
  end

endmodule

// File: tb/tb_field_buffer.sv
// Self-checking bench for field_buffer: vector table, directed clear/reset sequences and
// randomized traffic against a queue-based memory model.
module tb_field_buffer;
  localparam int DW = 8;
  localparam int BW = 3;
  localparam int FW = 5;
  localparam int AW = 8;
  localparam int NW = 256;
`ifdef FIELD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] buf_fieldp = '0, buf_fieldwp = '0, host_adr = '0;
  logic [DW-1:0] field_in = '0, host_wdata = '0;
  logic          field_write_en = 1'b0, host_valid = 1'b0, host_write = 1'b0, clear_req = 1'b0;
  logic [BW-1:0] clear_bank = '0;
  logic [DW-1:0] field_out, host_rdata;
  logic          host_ready, host_rvalid, clear_busy;

  field_buffer #(.d_width(DW), .bufp_width(BW), .fieldp_width(FW)) dut (
    .clk(clk), .reset(reset),
    .buf_fieldp(buf_fieldp), .field_out(field_out),
    .buf_fieldwp(buf_fieldwp), .field_write_en(field_write_en), .field_in(field_in),
    .host_valid(host_valid), .host_ready(host_ready), .host_write(host_write),
    .host_adr(host_adr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .clear_req(clear_req), .clear_bank(clear_bank), .clear_busy(clear_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain array plus a queue of addresses still awaiting zeroing
  logic [7:0] m_mem [NW];
  bit         m_known [NW];
  int         m_pending [$];
  bit         m_clearing = 1'b0;
  logic [7:0] m_fo = '0, m_rdata = '0;
  bit         m_rvalid = 1'b0, m_fo_known = 1'b0;
  logic [7:0] snap [NW];

  typedef struct {
    logic [7:0] wp;
    bit         we;
    logic [7:0] din;
    logic [7:0] rp;
    logic [7:0] exp_old;
    logic [7:0] exp_byp;
  } vec_t;
  vec_t vt [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  function automatic void mwrite(input int a, input logic [7:0] d);
    m_mem[a]   = d;
    m_known[a] = 1'b1;
  endfunction

  function automatic logic [7:0] initv(input int a);
    logic [7:0] v;
    v = 8'(a) ^ 8'h5A;
    return v;
  endfunction

  task automatic idle_inputs();
    buf_fieldwp = '0; field_write_en = 1'b0; field_in = '0;
    host_valid = 1'b0; host_write = 1'b0; host_adr = '0; host_wdata = '0;
    clear_req = 1'b0; clear_bank = '0;
  endtask

  task automatic model_reset();
    m_clearing = 1'b0;
    m_pending.delete();
    m_fo = '0; m_fo_known = 1'b1; m_rdata = '0; m_rvalid = 1'b0;
  endtask

  // One clock: check host_ready, advance the model across the edge, check registered outputs
  task automatic step();
    bit acc, was_clearing;
    int a;
    #1;
    chk("host_ready", host_ready, 32'(!field_write_en && !m_clearing));
    was_clearing = m_clearing;
    acc = host_valid && !field_write_en && !m_clearing;
    m_fo       = m_mem[buf_fieldp];
    m_fo_known = m_known[buf_fieldp];
    if (BYP && field_write_en && (buf_fieldwp == buf_fieldp)) begin
      m_fo = field_in; m_fo_known = 1'b1;
    end
    m_rvalid = acc && !host_write;
    if (m_rvalid) m_rdata = m_mem[host_adr];
    if (field_write_en) mwrite(int'(buf_fieldwp), field_in);
    else if (m_clearing) begin
      a = m_pending.pop_front();
      mwrite(a, 8'h00);
      if (m_pending.size() == 0) m_clearing = 1'b0;
    end else if (acc && host_write) mwrite(int'(host_adr), host_wdata);
    if (!was_clearing && clear_req) begin
      for (int f = 0; f < 32; f++) m_pending.push_back(int'(clear_bank) * 32 + f);
      m_clearing = 1'b1;
    end
    @(posedge clk);
    #1;
    if (m_fo_known) chk("field_out", field_out, m_fo);
    chk("host_rvalid", host_rvalid, m_rvalid);
    chk("host_rdata", host_rdata, m_rdata);
    chk("clear_busy", clear_busy, m_clearing);
  endtask

  task automatic pw(input logic [7:0] a, input logic [7:0] d);
    idle_inputs();
    field_write_en = 1'b1; buf_fieldwp = a; field_in = d;
    step();
  endtask

  task automatic rd(input logic [7:0] a);
    idle_inputs();
    buf_fieldp = a;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [7:0] a8;

    // Reset state
    #2 reset = 1'b1;
    #1;
    chk("rst_field_out", field_out, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_host_rvalid", host_rvalid, 0);
    chk("rst_clear_busy", clear_busy, 0);
    chk("rst_host_ready", host_ready, 1);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;

    // Known contents everywhere
    for (int a = 0; a < NW; a++) begin
      idle_inputs();
      field_write_en = 1'b1; buf_fieldwp = 8'(a); field_in = initv(a); buf_fieldp = 8'(a);
      step();
    end

    // Processor write / read vectors
    vt[0] = '{8'h23, 1'b1, 8'hA5, 8'h10, 8'h4A, 8'h4A};
    vt[1] = '{8'h00, 1'b0, 8'h00, 8'h23, 8'hA5, 8'hA5};
    vt[2] = '{8'h50, 1'b1, 8'h11, 8'h23, 8'hA5, 8'hA5};
    vt[3] = '{8'h50, 1'b1, 8'h77, 8'h50, 8'h11, 8'h77};
    vt[4] = '{8'h00, 1'b0, 8'h00, 8'h50, 8'h77, 8'h77};
    vt[5] = '{8'hFF, 1'b1, 8'h00, 8'hFF, 8'hA5, 8'h00};
    vt[6] = '{8'h00, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00};
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      field_write_en = vt[i].we; buf_fieldwp = vt[i].wp; field_in = vt[i].din; buf_fieldp = vt[i].rp;
      step();
      chk($sformatf("vec%0d", i), field_out, BYP ? vt[i].exp_byp : vt[i].exp_old);
    end

    // Host write blocked by processor write, then lands; host read back
    idle_inputs();
    field_write_en = 1'b1; buf_fieldwp = 8'h60; field_in = 8'h12;
    host_valid = 1'b1; host_write = 1'b1; host_adr = 8'h41; host_wdata = 8'h3C;
    #1 chk("host_ready_blocked", host_ready, 0);
    step();
    field_write_en = 1'b0;
    step();
    host_write = 1'b0;
    #1 chk("host_ready_free", host_ready, 1);
    step();
    chk("host_rvalid_pulse", host_rvalid, 1);
    chk("host_rdata_3c", host_rdata, 8'h3C);
    idle_inputs();
    step();
    chk("host_rvalid_drop", host_rvalid, 0);
    chk("host_rdata_hold", host_rdata, 8'h3C);

    // Bank 2 fill then clear without processor interference
    for (int f = 0; f < 32; f++) pw(8'(2 * 32 + f), 8'hFF);
    for (int a = 0; a < NW; a++) snap[a] = m_mem[a];
    idle_inputs(); clear_req = 1'b1; clear_bank = 3'd2;
    step();
    cnt = clear_busy ? 1 : 0;
    for (int k = 0; k < 100; k++) begin
      idle_inputs();
      step();
      if (!clear_busy) break;
      cnt++;
    end
    chk("clear_len_32", cnt, 32);
    for (int f = 0; f < 32; f++) begin
      rd(8'(2 * 32 + f));
      chk($sformatf("bank2_zero_%0d", f), field_out, 0);
    end
    for (int f = 0; f < 32; f += 5) begin
      rd(8'(32 + f));
      chk($sformatf("bank1_keep_%0d", f), field_out, snap[32 + f]);
      rd(8'(96 + f));
      chk($sformatf("bank3_keep_%0d", f), field_out, snap[96 + f]);
    end

    // Clear of bank 3 with three injected processor writes and an ignored clear_req
    idle_inputs(); clear_req = 1'b1; clear_bank = 3'd3;
    step();
    cnt = clear_busy ? 1 : 0;
    for (int k = 1; k < 100; k++) begin
      idle_inputs();
      case (k)
        3: begin clear_req = 1'b1; clear_bank = 3'd6; end
        4: begin field_write_en = 1'b1; buf_fieldwp = 8'h60; field_in = 8'hC3; end
        5: begin field_write_en = 1'b1; buf_fieldwp = 8'h7F; field_in = 8'hD4; end
        6: begin field_write_en = 1'b1; buf_fieldwp = 8'hA7; field_in = 8'hE5; end
        default: ;
      endcase
      step();
      if (!clear_busy) break;
      cnt++;
    end
    chk("clear_len_35", cnt, 35);
    rd(8'h60); chk("cleared_then_written", field_out, 8'hC3);
    rd(8'h7F); chk("written_then_cleared", field_out, 8'h00);
    rd(8'hA7); chk("other_bank_write", field_out, 8'hE5);
    rd(8'hC0); chk("ignored_clear_bank6", field_out, initv(8'hC0));

    // Reset in the middle of a bank 4 clear at counter 10
    idle_inputs(); clear_req = 1'b1; clear_bank = 3'd4;
    host_valid = 1'b1; host_write = 1'b0; host_adr = 8'h05; buf_fieldp = 8'hC1;
    step();
    for (int k = 0; k < 10; k++) begin
      idle_inputs();
      step();
    end
    chk("pre_rst_busy", clear_busy, 1);
    chk("pre_rst_rdata", host_rdata, initv(8'h05));
    chk("pre_rst_field_out", field_out, initv(8'hC1));
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", clear_busy, 0);
    chk("mid_rst_field_out", field_out, 0);
    chk("mid_rst_rdata", host_rdata, 0);
    chk("mid_rst_rvalid", host_rvalid, 0);
    model_reset();
    @(posedge clk); #1;
    chk("rst_hold_busy", clear_busy, 0);
    reset = 1'b0;
    for (int f = 0; f < 32; f++) begin
      a8 = 8'(128 + f);
      rd(a8);
      chk($sformatf("bank4_partial_%0d", f), field_out, (f < 10) ? 8'h00 : initv(a8));
    end

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      idle_inputs();
      field_write_en = ($urandom_range(0, 99) < 30);
      buf_fieldwp    = 8'($urandom);
      field_in       = 8'($urandom);
      buf_fieldp     = ($urandom_range(0, 3) == 0) ? buf_fieldwp : 8'($urandom);
      host_valid     = $urandom_range(0, 1) == 1;
      host_write     = $urandom_range(0, 1) == 1;
      host_adr       = 8'($urandom);
      host_wdata     = 8'($urandom);
      clear_req      = ($urandom_range(0, 99) < 3);
      clear_bank     = 3'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
